cordic_job_arbiter: RTL and testbench

//   Shares one bit-serial CORDIC engine among NREQ requesters. Accepts (x0,y0,z0) jobs by

---
 rtl/cordic_job_arbiter.sv | 136 +++++++++++++
 tb/tb_cordic_job_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_arbiter.sv
// Round-robin arbiter that time-shares one bit-serial CORDIC engine among NREQ requesters,
// with a watchdog that aborts a job the engine never finishes.
module cordic_job_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_x0,
   input  logic [NREQ*W-1:0] req_y0,
   input  logic [NREQ*W-1:0] req_z0,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_x,
   output logic [W-1:0]      rsp_y,
   output logic              rsp_err,
   output logic              eng_start,
   output logic [W-1:0]      eng_x0,
   output logic [W-1:0]      eng_y0,
   output logic [W-1:0]      eng_z0,
   input  logic              eng_done,
   input  logic [W-1:0]      eng_x,
   input  logic [W-1:0]      eng_y,
   output logic              busy,
   output logic [2:0]        grant_id
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StIssue, StArm, StWait, StDeliver} state_t;

   state_t          state;
   logic [2:0]      last;
   logic [CW-1:0]   cnt;
   logic [NREQ-1:0] grant_oh;

   logic            found;
   logic [2:0]      winner;
   logic [NREQ-1:0] win_oh;
   logic [W-1:0]    sel_x0, sel_y0, sel_z0;
   int unsigned     idx;

   // Scan starting just after the last winner so every holder is served within NREQ jobs.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      win_oh = '0;
      sel_x0 = '0;
      sel_y0 = '0;
      sel_z0 = '0;
      idx    = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(last) + i) % NREQ;
         if (!found && req_valid[idx]) begin
            found       = 1'b1;
            winner      = 3'(idx);
            win_oh[idx] = 1'b1;
            sel_x0      = req_x0[idx*W +: W];
            sel_y0      = req_y0[idx*W +: W];
            sel_z0      = req_z0[idx*W +: W];
         end
      end
   end

   assign req_ready = (state == StIdle && !rst) ? win_oh : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         last      <= 3'(NREQ - 1);
         cnt       <= '0;
         grant_oh  <= '0;
         grant_id  <= '0;
         rsp_valid <= '0;
         rsp_x     <= '0;
         rsp_y     <= '0;
         rsp_err   <= 1'b0;
         eng_start <= 1'b0;
         eng_x0    <= '0;
         eng_y0    <= '0;
         eng_z0    <= '0;
         busy      <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         unique case (state)
            StIdle: begin
               if (found) begin
                  eng_x0    <= sel_x0;
                  eng_y0    <= sel_y0;
                  eng_z0    <= sel_z0;
                  grant_id  <= winner;
                  last      <= winner;
                  grant_oh  <= win_oh;
                  busy      <= 1'b1;
                  eng_start <= 1'b1;
                  state     <= StIssue;
               end
            end
            StIssue: state <= StArm;
            // eng_done may still reflect the previous job here, so it is not looked at.
            StArm: begin
               cnt   <= '0;
               state <= StWait;
            end
            StWait: begin
               cnt <= cnt + 1'b1;
               if (eng_done) begin
                  rsp_x     <= eng_x;
                  rsp_y     <= eng_y;
                  rsp_err   <= 1'b0;
                  rsp_valid <= grant_oh;
                  state     <= StDeliver;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_x     <= '0;
                  rsp_y     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= grant_oh;
                  state     <= StDeliver;
               end
            end
            StDeliver: begin
               if (|(rsp_valid & rsp_ready)) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Scoreboard bench for cordic_job_arbiter: directed jobs, a behavioural engine model,
// and negedge monitors for grants and responses.
module tb_cordic_job_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 16;
   localparam int TIMEOUT = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x0, req_y0, req_z0;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [W-1:0]      rsp_x, rsp_y;
   logic              rsp_err;
   logic              eng_start;
   logic [W-1:0]      eng_x0, eng_y0, eng_z0;
   logic              eng_done;
   logic [W-1:0]      eng_x, eng_y;
   logic              busy;
   logic [2:0]        grant_id;

   cordic_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x0    (req_x0),
      .req_y0    (req_y0),
      .req_z0    (req_z0),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_x     (rsp_x),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .eng_start (eng_start),
      .eng_x0    (eng_x0),
      .eng_y0    (eng_y0),
      .eng_z0    (eng_z0),
      .eng_done  (eng_done),
      .eng_x     (eng_x),
      .eng_y     (eng_y),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [15:0] x0, y0, z0, rx, ry;
      int          lat;
      bit          stale, never;
   } job_t;

   typedef struct {
      int          id;
      logic [15:0] x, y;
      bit          err;
      int          delta;
   } rsp_t;

   job_t eng_q[$];
   rsp_t rsp_q[$];
   int   grant_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int accept_cyc = 0;
   int grant_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Expected response delay from the start-pulse cycle to the first rsp_valid cycle.
   task automatic push_job(input int id, input logic [15:0] x0, y0, z0, rx, ry,
                           input int lat, input bit stale, input bit never);
      job_t j;
      rsp_t r;
      j.id = id; j.x0 = x0; j.y0 = y0; j.z0 = z0; j.rx = rx; j.ry = ry;
      j.lat = lat; j.stale = stale; j.never = never;
      r.id    = id;
      r.x     = never ? 16'h0000 : rx;
      r.y     = never ? 16'h0000 : ry;
      r.err   = never;
      r.delta = never ? TIMEOUT + 2 : (stale ? lat + 3 : lat + 1);
      grant_q.push_back(id);
      eng_q.push_back(j);
      rsp_q.push_back(r);
   endtask

   task automatic raise(input int id, input logic [15:0] x0, y0, z0);
      req_valid[id]       = 1'b1;
      req_x0[id*W +: W]   = x0;
      req_y0[id*W +: W]   = y0;
      req_z0[id*W +: W]   = z0;
   endtask

   task automatic wait_grants(input int target);
      int n = 0;
      while (grant_count < target && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (grant_count < target) fail_now("grant_wait", "expected accept never came");
   endtask

   task automatic wait_drain();
      int n = 0;
      while (rsp_q.size() != 0 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (rsp_q.size() != 0) fail_now("drain_wait", "expected responses never delivered");
      @(posedge clk); #1;
   endtask

   // Engine model: checks the issued operands, then raises done after the job's latency.
   initial begin
      job_t j;
      eng_done = 1'b0;
      eng_x    = '0;
      eng_y    = '0;
      forever begin
         @(posedge clk); #1;
         if (eng_start) begin
            if (eng_q.size() == 0) begin
               fail_now("eng_unexpected", "start pulse with no job queued");
            end else begin
               j = eng_q.pop_front();
               start_cyc = cyc;
               chk("start_lat", cyc - accept_cyc, 1);
               chk("eng_x0", eng_x0, j.x0);
               chk("eng_y0", eng_y0, j.y0);
               chk("eng_z0", eng_z0, j.z0);
               chk("grant_id", grant_id, j.id);
               chk("busy_job", busy, 1);
               if (j.stale) begin
                  repeat (2) begin @(posedge clk); #1; end
               end
               eng_done = 1'b0;
               if (!j.never) begin
                  repeat (j.lat) @(posedge clk);
                  #1;
                  eng_x    = j.rx;
                  eng_y    = j.ry;
                  eng_done = 1'b1;
               end
            end
         end
      end
   end

   // Grant monitor.
   initial begin
      int  gid;
      logic prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (|req_ready) begin
            if (grant_q.size() == 0) begin
               fail_now("grant_unexpected", "req_ready with no grant expected");
            end else begin
               gid = grant_q.pop_front();
               chk("req_ready", 32'(req_ready), 32'd1 << gid);
               chk("grant_idle", busy, 0);
               accept_cyc = cyc;
               grant_count++;
            end
         end
         if (eng_start) chk("start_pulse", prev_start, 0);
         prev_start = eng_start;
      end
   end

   // Response monitor: latency on rise, stability while held, contents on handshake.
   initial begin
      rsp_t       r;
      logic       prev_valid = 1'b0;
      logic [3:0] snap_v = '0;
      logic [15:0] snap_x = '0, snap_y = '0;
      logic       snap_e = 1'b0;
      forever begin
         @(negedge clk);
         if (|rsp_valid) begin
            if (!prev_valid) begin
               if (rsp_q.size() == 0) fail_now("rsp_unexpected", "rsp_valid with no job expected");
               else chk("rsp_lat", cyc - start_cyc, rsp_q[0].delta);
            end else begin
               chk("hold_valid", rsp_valid, snap_v);
               chk("hold_x", rsp_x, snap_x);
               chk("hold_y", rsp_y, snap_y);
               chk("hold_err", rsp_err, snap_e);
            end
            snap_v = rsp_valid; snap_x = rsp_x; snap_y = rsp_y; snap_e = rsp_err;
            if (|(rsp_valid & rsp_ready)) begin
               if (rsp_q.size() != 0) begin
                  r = rsp_q.pop_front();
                  chk("rsp_valid", 32'(rsp_valid), 32'd1 << r.id);
                  chk("rsp_x", rsp_x, r.x);
                  chk("rsp_y", rsp_y, r.y);
                  chk("rsp_err", rsp_err, r.err);
               end
               prev_valid = 1'b0;
            end else begin
               prev_valid = 1'b1;
            end
         end else begin
            prev_valid = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int n;
      rst       = 1'b1;
      req_valid = '0;
      req_x0    = '0;
      req_y0    = '0;
      req_z0    = '0;
      rsp_ready = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_x", rsp_x, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_eng_x0", eng_x0, 0);
      chk("rst_eng_y0", eng_y0, 0);
      chk("rst_eng_z0", eng_z0, 0);
      chk("rst_grant_id", grant_id, 0);
      rst = 1'b0;

      // Round robin from reset: all four held, grant order 0,1,2,3,0.
      push_job(0, 16'h1000, 16'h2000, 16'h3000, 16'h0A00, 16'h0B00, 3, 0, 0);
      push_job(1, 16'h1001, 16'h2001, 16'h3001, 16'h0A01, 16'h0B01, 4, 0, 0);
      push_job(2, 16'h1002, 16'h2002, 16'h3002, 16'h0A02, 16'h0B02, 5, 0, 0);
      push_job(3, 16'h1003, 16'h2003, 16'h3003, 16'h0A03, 16'h0B03, 6, 0, 0);
      push_job(0, 16'h1000, 16'h2000, 16'h3000, 16'h0A04, 16'h0B04, 7, 0, 0);
      for (int k = 0; k < NREQ; k++)
         raise(k, 16'(16'h1000 + k), 16'(16'h2000 + k), 16'(16'h3000 + k));
      wait_grants(5);
      req_valid = '0;
      wait_drain();

      // Single job on id 2 with a 240-cycle engine.
      g = grant_count;
      push_job(2, 16'h4000, 16'h0000, 16'h1922, 16'h2D41, 16'h2D41, 240, 0, 0);
      raise(2, 16'h4000, 16'h0000, 16'h1922);
      wait_grants(g + 1);
      req_valid[2] = 1'b0;
      wait_drain();

      // Stale done held through ISSUE/ARM from the previous job.
      g = grant_count;
      push_job(1, 16'h1111, 16'h2222, 16'h0C90, 16'h7FFF, 16'h8001, 6, 1, 0);
      raise(1, 16'h1111, 16'h2222, 16'h0C90);
      wait_grants(g + 1);
      req_valid[1] = 1'b0;
      wait_drain();

      // Timeout, then a normal job with the minimum engine latency.
      g = grant_count;
      push_job(3, 16'h0123, 16'h0456, 16'h0789, 16'h5555, 16'h6666, 0, 0, 1);
      raise(3, 16'h0123, 16'h0456, 16'h0789);
      wait_grants(g + 1);
      req_valid[3] = 1'b0;
      wait_drain();
      g = grant_count;
      push_job(0, 16'h4000, 16'h4000, 16'hE6DE, 16'h5A82, 16'h0000, 2, 0, 0);
      raise(0, 16'h4000, 16'h4000, 16'hE6DE);
      wait_grants(g + 1);
      req_valid[0] = 1'b0;
      wait_drain();

      // Backpressure on id 1 while id 2 waits; other rsp_ready bits are high.
      g = grant_count;
      push_job(1, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h1234, 16'hFEDC, 10, 0, 0);
      push_job(2, 16'h0DDD, 16'h0EEE, 16'h0FFF, 16'h4321, 16'hCDEF, 7, 0, 0);
      rsp_ready = 4'b1101;
      raise(1, 16'h0AAA, 16'h0BBB, 16'h0CCC);
      raise(2, 16'h0DDD, 16'h0EEE, 16'h0FFF);
      wait_grants(g + 1);
      req_valid[1] = 1'b0;
      n = 0;
      while (!rsp_valid[1] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid[1]) fail_now("bp_wait", "rsp_valid[1] never rose");
      repeat (20) @(posedge clk);
      #1;
      rsp_ready = '1;
      wait_grants(g + 2);
      req_valid[2] = 1'b0;
      wait_drain();

      // Reset while waiting on an engine that never finishes.
      g = grant_count;
      push_job(3, 16'h0321, 16'h0654, 16'h0987, 16'h0000, 16'h0000, 0, 0, 1);
      raise(3, 16'h0321, 16'h0654, 16'h0987);
      wait_grants(g + 1);
      req_valid[3] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      void'(rsp_q.pop_back());
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("wrst_busy", busy, 0);
      chk("wrst_eng_start", eng_start, 0);
      chk("wrst_rsp_valid", rsp_valid, 0);
      chk("wrst_grant_id", grant_id, 0);
      chk("wrst_eng_x0", eng_x0, 0);
      g = grant_count;
      push_job(0, 16'h7000, 16'h0100, 16'h0200, 16'h1357, 16'h2468, 4, 0, 0);
      raise(0, 16'h7000, 16'h0100, 16'h0200);
      raise(2, 16'h7002, 16'h0102, 16'h0202);
      wait_grants(g + 1);
      req_valid = '0;
      wait_drain();
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
